// File: rtl/fetch_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_align: word fetch into a 3-halfword buffer, emits aligned 16/32-bit |
// | instructions. Optional macro COMPRESSED_EN enables halfword alignment.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o
);

`ifdef COMPRESSED_EN
  localparam logic C_COMP = 1'b1;
`else
  localparam logic C_COMP = 1'b0;
`endif
  localparam logic [31:0] C_PC_MASK   = C_COMP ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [15:0] buf_q [3];
  logic [15:0] buf_d [3];
  logic [1:0]  count_q, count_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] pc_q, pc_d;
  logic        skip_q, skip_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        comp_q, comp_d;

  logic [1:0]  consumed;
  logic [1:0]  rem;
  logic        rsp;
  logic [2:0]  src;
  logic [2:0]  pos;
  logic [15:0] lo_half;
  logic        head_comp;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    fetch_d  = fetch_q;
    pc_d     = pc_q;
    skip_d   = skip_q;
    src      = 3'd0;
    consumed = 2'd0;

    if (valid_q && instr_ready_i) consumed = comp_q ? 2'd1 : 2'd2;
    rem = count_q - consumed;

    // Request only when the buffer will have room for a full word on return.
    imem_req_o = (state_q == FETCH) && !redirect_i && (rem <= 2'd1);
    rsp        = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    lo_half    = skip_q ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    pos        = {1'b0, rem};

    for (int i = 0; i < 3; i++) begin
      src      = 3'(i) + {1'b0, consumed};
      buf_d[i] = (src < 3'd3) ? buf_q[src[1:0]] : buf_q[i];
    end
    for (int i = 0; i < 3; i++) begin
      if (rsp && (3'(i) == pos)) buf_d[i] = lo_half;
      if (rsp && !skip_q && (3'(i) == pos + 3'd1)) buf_d[i] = imem_rdata_i[31:16];
    end

    count_d = rsp ? (rem + (skip_q ? 2'd1 : 2'd2)) : rem;
    pc_d    = pc_q + {29'd0, consumed, 1'b0};
    if (imem_req_o) fetch_d = fetch_q + 32'd4;
    if (rsp) skip_d = 1'b0;

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (imem_req_o) state_d = WAIT;
      WAIT:    if (imem_rvalid_i) state_d = FETCH;
      DISCARD: if (imem_rvalid_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    // A redirect with a response still in flight must swallow that response.
    if (redirect_i) begin
      count_d = 2'd0;
      pc_d    = redirect_pc_i & C_PC_MASK;
      fetch_d = redirect_pc_i & C_WORD_MASK;
      skip_d  = C_COMP & redirect_pc_i[1];
      state_d = (((state_q == WAIT) || (state_q == DISCARD)) && !imem_rvalid_i) ? DISCARD : FETCH;
    end

    head_comp = C_COMP && (buf_d[0][1:0] != 2'b11);
    valid_d   = (count_d >= 2'd2) || ((count_d != 2'd0) && head_comp);
    comp_d    = valid_d && head_comp;
    if (!valid_d)    instr_d = 32'h0;
    else if (comp_d) instr_d = {16'h0, buf_d[0]};
    else             instr_d = {buf_d[1], buf_d[0]};
  end

  assign imem_addr_o        = imem_req_o ? fetch_q : 32'h0;
  assign instr_valid_o      = valid_q;
  assign instr_o            = instr_q;
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = comp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      count_q <= 2'd0;
      fetch_q <= RESET_PC & C_WORD_MASK;
      pc_q    <= RESET_PC & C_PC_MASK;
      skip_q  <= C_COMP & RESET_PC[1];
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      comp_q  <= 1'b0;
      for (int i = 0; i < 3; i++) buf_q[i] <= 16'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fetch_q <= fetch_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      comp_q  <= comp_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align.sv
`default_nettype none
// tb_fetch_align: scoreboard bench; an instruction-level model of memory contents
// predicts the accepted instruction stream after each reset or redirect.
module tb_fetch_align;

`ifdef COMPRESSED_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;

  always #5 clk = ~clk;

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_compressed_o(instr_compressed_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] next_pc;
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return 32'h0000_0013;
  endfunction

  function automatic logic [15:0] rd_half(input logic [31:0] a);
    logic [31:0] w;
    w = rd_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t        e;
    pc = COMP ? {start[31:1], 1'b0} : {start[31:2], 2'b00};
    for (int k = 0; k < n; k++) begin
      h       = rd_half(pc);
      e.comp  = COMP && (h[1:0] != 2'b11);
      e.pc    = pc;
      e.instr = e.comp ? {16'h0, h} : {rd_half(pc + 32'd2), h};
      sb.push_back(e);
      pc = pc + (e.comp ? 32'd2 : 32'd4);
    end
    next_pc = pc;
  endtask

  // Memory: one response per request, lat cycles later; stale responses survive reset.
  initial begin : memory
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = rd_word(paddr);
          pend = 1'b0;
        end else cnt--;
      end
      if (imem_req_o) begin
        check("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr_o;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
        if (sb.size() == 0) check("extra_accept", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("instr", instr_o, e.instr);
          check("pc", instr_pc_o, e.pc);
          check("comp", {31'd0, instr_compressed_o}, {31'd0, e.comp});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t, input int n);
    redirect_i    = 1'b1;
    redirect_pc_i = t;
    sb.delete();
    push_stream(t, n);
    step();
    redirect_i = 1'b0;
    check("valid_after_redirect", {31'd0, instr_valid_o}, 32'd0);
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      step();
      if (sb.size() == 0) break;
      instr_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    instr_ready_i = 1'b0;
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  // Leaves the time at #1 after the edge that registered the request.
  task automatic wait_req(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (imem_req_o) seen = 1'b1;
    end
    check("req_seen", {31'd0, seen}, 32'd1);
    step();
  endtask

  task automatic expect_fetch(input logic [31:0] addr);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (imem_req_o) begin
        seen = 1'b1;
        check("first_fetch_addr", imem_addr_o, addr);
      end
    end
    check("first_fetch_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin : stim
    rst_n = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    next_pc = 32'h0;
    mem[32'h000] = 32'h0000_0013;
    mem[32'h004] = 32'h0010_0093;
    mem[32'h008] = 32'h0020_0113;
    mem[32'h00C] = 32'h0031_0193;
    mem[32'h100] = 32'h4505_0013;
    mem[32'h104] = 32'h0041_0213;
    mem[32'h200] = 32'h0001_4501;
    mem[32'h204] = 32'h0000_0013;
    mem[32'h300] = 32'h0013_4505;
    mem[32'h304] = 32'h0000_0000;
    for (int a = 32'h400; a < 32'h480; a += 4) mem[32'(a)] = $urandom;

    #12;
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_comp", {31'd0, instr_compressed_o}, 32'd0);
    check("rst_pc", instr_pc_o, 32'h0);

    // First valid appears on the third edge after release with a 1-cycle memory.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("boot_valid", {31'd0, instr_valid_o}, 32'd0);
    check("boot_req", {31'd0, imem_req_o}, 32'd1);
    check("boot_addr", imem_addr_o, 32'h0);
    step();
    check("wait_valid", {31'd0, instr_valid_o}, 32'd0);
    step();
    check("first_valid", {31'd0, instr_valid_o}, 32'd1);
    check("first_instr", instr_o, 32'h0000_0013);
    check("first_pc", instr_pc_o, 32'h0);
    check("first_comp", {31'd0, instr_compressed_o}, 32'd0);

    // Stall with the buffer full.
    push_stream(32'h0, 8);
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", {31'd0, instr_valid_o}, 32'd1);
      check("stall_instr", instr_o, sb[0].instr);
      check("stall_pc", instr_pc_o, sb[0].pc);
      check("stall_comp", {31'd0, instr_compressed_o}, {31'd0, sb[0].comp});
      check("stall_req", {31'd0, imem_req_o}, 32'd0);
    end
    drain(1'b0, 200);
    push_stream(next_pc, 10);
    drain(1'b1, 400);

    // Redirect to 0x102 with a response outstanding.
    push_stream(next_pc, 30);
    instr_ready_i = 1'b1;
    lat = 3;
    wait_req(40);
    redirect_to(32'h0000_0102, 6);
    expect_fetch(32'h0000_0100);
    lat = 1;
    drain(1'b0, 200);

    // Second redirect while already discarding; exactly one response dropped.
    push_stream(next_pc, 30);
    instr_ready_i = 1'b1;
    lat = 4;
    wait_req(40);
    redirect_to(32'h0000_0300, 4);
    redirect_to(32'h0000_0200, 6);
    expect_fetch(32'h0000_0200);
    lat = 1;
    drain(1'b0, 200);

    // Compressed then 32-bit spanning a word boundary.
    redirect_to(32'h0000_0300, 4);
    drain(1'b0, 200);

    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(1, 3);
      redirect_to(32'h400 + 32'($urandom_range(0, 40)) * 32'd2, 10);
      drain(1'b1, 600);
    end

    // Reset while a request is outstanding; its late response must be ignored.
    push_stream(next_pc, 30);
    instr_ready_i = 1'b1;
    lat = 3;
    wait_req(40);
    rst_n = 1'b0;
    sb.delete();
    instr_ready_i = 1'b0;
    step();
    check("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("midrst_pc", instr_pc_o, 32'h0);
    check("midrst_req", {31'd0, imem_req_o}, 32'd0);
    rst_n = 1'b1;
    lat = 1;
    push_stream(32'h0, 6);
    drain(1'b0, 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
